// File: rtl/sha2_arb.sv
// Whole-message round-robin arbiter sharing one sha2 core among N_REQ streaming requesters.
// The owner keeps the core from its first input word until the last digest word is drained.
module sha2_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned D_WIDTH = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [2*N_REQ-1:0]         req_mode_i,
    input  logic [D_WIDTH*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]           req_last_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    output logic [D_WIDTH-1:0]         rsp_data_o,
    output logic [N_REQ-1:0]           rsp_valid_o,
    input  logic [N_REQ-1:0]           rsp_ready_i,
    output logic [1:0]                 core_mode_o,
    output logic                       core_last_o,
    output logic [D_WIDTH-1:0]         core_data_o,
    output logic                       core_valid_o,
    input  logic                       core_ready_i,
    input  logic [D_WIDTH-1:0]         core_out_data_i,
    input  logic                       core_out_valid_i,
    output logic                       core_out_ready_o,
    output logic [N_REQ-1:0]           grant_o,
    output logic                       busy_o
);

    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StFeed, StDrain} state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    g_q, g_d;
    logic [GW-1:0]    ptr_q, ptr_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;

    logic [D_WIDTH-1:0] req_data_a [N_REQ];
    logic [1:0]         req_mode_a [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_data_a[i] = req_data_i[i*D_WIDTH +: D_WIDTH];
        assign req_mode_a[i] = req_mode_i[2*i +: 2];
    end

    // First valid requester searching ptr, ptr+1, ... modulo N_REQ.
    logic          found;
    logic [GW-1:0] pick;
    logic [GW-1:0] idx;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = GW'((32'(ptr_q) + i) % N_REQ);
            if (!found && req_valid_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    logic [3:0] len_m1;

    always_comb begin
        unique case (mode_q)
            2'd0, 2'd1: len_m1 = 4'd3;
            2'd2:       len_m1 = 4'd5;
            default:    len_m1 = 4'd7;
        endcase
    end

    always_comb begin
        req_ready_o      = '0;
        rsp_valid_o      = '0;
        core_valid_o     = 1'b0;
        core_last_o      = 1'b0;
        core_out_ready_o = 1'b0;
        unique case (state_q)
            StFeed: begin
                core_valid_o     = req_valid_i[g_q];
                core_last_o      = req_last_i[g_q];
                req_ready_o[g_q] = core_ready_i;
            end
            StDrain: begin
                rsp_valid_o[g_q] = core_out_valid_i;
                core_out_ready_o = rsp_ready_i[g_q];
            end
            default: ;
        endcase
    end

    assign core_data_o = req_data_a[g_q];
    assign rsp_data_o  = core_out_data_i;
    assign core_mode_o = mode_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != StIdle);

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    g_d     = pick;
                    grant_d = N_REQ'(1) << pick;
                    mode_d  = req_mode_a[pick];
                    cnt_d   = '0;
                    state_d = StFeed;
                end
            end
            StFeed: begin
                if (core_valid_o && core_ready_i && core_last_o) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (core_out_valid_i && rsp_ready_i[g_q]) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == len_m1) begin
                        state_d = StIdle;
                        grant_d = '0;
                        ptr_d   = (g_q == GW'(N_REQ - 1)) ? '0 : g_q + GW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            g_q     <= '0;
            ptr_q   <= '0;
            mode_q  <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_sha2_arb.sv
// Directed bench for sha2_arb: the bench plays both the requesters and the sha2 core.
module tb_sha2_arb;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2*N-1:0]  req_mode = '0;
    logic [DW*N-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   rsp_data;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [1:0]      core_mode;
    logic            core_last;
    logic [DW-1:0]   core_data;
    logic            core_valid;
    logic            core_ready = 1'b0;
    logic [DW-1:0]   core_out_data = '0;
    logic            core_out_valid = 1'b0;
    logic            core_out_ready;
    logic [N-1:0]    grant;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    sha2_arb #(.N_REQ(N), .D_WIDTH(DW)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .req_mode_i       (req_mode),
        .req_data_i       (req_data),
        .req_last_i       (req_last),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .rsp_data_o       (rsp_data),
        .rsp_valid_o      (rsp_valid),
        .rsp_ready_i      (rsp_ready),
        .core_mode_o      (core_mode),
        .core_last_o      (core_last),
        .core_data_o      (core_data),
        .core_valid_o     (core_valid),
        .core_ready_i     (core_ready),
        .core_out_data_i  (core_out_data),
        .core_out_valid_i (core_out_valid),
        .core_out_ready_o (core_out_ready),
        .grant_o          (grant),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned sum_seq(input int base, input int n);
        longint unsigned s;
        s = 0;
        for (int i = 0; i < n; i++) s += 64'(base + i);
        return s;
    endfunction

    task automatic idle_core;
        core_out_valid = 1'b0;
        rsp_ready      = '0;
        core_ready     = 1'b0;
    endtask

    // Streams nwords words from requester r; counts accepted beats and sums the core-side data.
    task automatic do_feed(input int r, input int nwords, input int base, input bit stall,
                           output int beats, output longint unsigned sum);
        int i;
        int cyc;
        i = 0; cyc = 0; beats = 0; sum = 0;
        while (i < nwords && cyc < 60) begin
            req_data[r*DW +: DW] = DW'(base + i);
            req_last[r]  = (i == nwords - 1);
            req_valid[r] = 1'b1;
            core_ready   = stall ? (cyc % 2 == 0) : 1'b1;
            #2;
            if (core_valid && core_ready && req_ready[r]) begin
                beats++;
                sum += core_data;
                i++;
            end
            tick;
            cyc++;
        end
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
        core_ready   = 1'b0;
    endtask

    // Core keeps offering digest words; returns once grant drops (IDLE), sampled at +3.
    task automatic do_drain(input int r, input int base, input bit stall,
                            output int beats, output longint unsigned sum);
        int k;
        int cyc;
        k = 0; cyc = 0; beats = 0; sum = 0;
        while (cyc < 40) begin
            core_out_valid = 1'b1;
            core_out_data  = DW'(base + k);
            rsp_ready[r]   = stall ? (cyc % 3 != 1) : 1'b1;
            #2;
            if (beats > 0 && grant == '0) break;
            if (rsp_valid[r] && core_out_ready) begin
                beats++;
                sum += rsp_data;
                k++;
            end
            tick;
            cyc++;
        end
    endtask

    task automatic test_reset;
        req_valid = 4'b1111;
        tick; tick;
        #2;
        if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant); end n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end n_cmp++;
        if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end n_cmp++;
        if (core_mode !== 2'd0) begin n_err++; $display("FAIL reset_core_mode: got %0d want 0", core_mode); end n_cmp++;
        if (core_valid !== 1'b0 || core_out_ready !== 1'b0 || rsp_valid !== 4'b0000) begin
            n_err++; $display("FAIL reset_valids: got cv=%b cor=%b rv=%b want 0/0/0000", core_valid, core_out_ready, rsp_valid);
        end n_cmp++;
        req_valid = '0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        int b;
        longint unsigned s;
        req_mode[1:0] = 2'd1;
        req_valid[0]  = 1'b1;
        core_ready    = 1'b0;
        #2;
        if (grant !== 4'b0000) begin n_err++; $display("FAIL single_grant_early: got %b want 0000", grant); end n_cmp++;
        tick;
        req_mode[1:0] = 2'd3;
        #2;
        if (grant !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", grant); end n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end n_cmp++;
        if (core_mode !== 2'd1) begin n_err++; $display("FAIL single_mode: got %0d want 1", core_mode); end n_cmp++;
        tick;
        do_feed(0, 3, 'h100, 1'b0, b, s);
        if (b !== 3) begin n_err++; $display("FAIL single_feed_beats: got %0d want 3", b); end n_cmp++;
        if (s !== sum_seq('h100, 3)) begin n_err++; $display("FAIL single_feed_sum: got %0h want %0h", s, sum_seq('h100, 3)); end n_cmp++;
        #2;
        if (core_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_err++; $display("FAIL single_feed_closed: got cv=%b rr=%b want 0/0000", core_valid, req_ready);
        end n_cmp++;
        tick;
        do_drain(0, 'h200, 1'b0, b, s);
        if (b !== 4) begin n_err++; $display("FAIL single_drain_beats: got %0d want 4", b); end n_cmp++;
        if (s !== sum_seq('h200, 4)) begin n_err++; $display("FAIL single_drain_sum: got %0h want %0h", s, sum_seq('h200, 4)); end n_cmp++;
        if (core_out_ready !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL single_done: got cor=%b busy=%b want 0/0", core_out_ready, busy);
        end n_cmp++;
        idle_core;
    endtask

    // ptr is 1 now: with 0 and 3 requesting, 3 wins; the 1-beat message and handoff follow.
    task automatic test_ptr_one_beat;
        int b;
        longint unsigned s;
        tick;
        req_mode[1:0] = 2'd3;
        req_mode[7:6] = 2'd0;
        req_valid[0]  = 1'b1;
        req_valid[3]  = 1'b1;
        tick;
        #2;
        if (grant !== 4'b1000) begin n_err++; $display("FAIL ptr_grant: got %b want 1000", grant); end n_cmp++;
        tick;
        do_feed(3, 1, 'h300, 1'b0, b, s);
        if (b !== 1) begin n_err++; $display("FAIL onebeat_feed_beats: got %0d want 1", b); end n_cmp++;
        #2;
        if (grant !== 4'b1000 || core_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL onebeat_drain_entry: got g=%b cv=%b busy=%b want 1000/0/1", grant, core_valid, busy);
        end n_cmp++;
        tick;
        do_drain(3, 'h400, 1'b0, b, s);
        if (b !== 4) begin n_err++; $display("FAIL onebeat_drain_beats: got %0d want 4", b); end n_cmp++;
        if (grant !== 4'b0000) begin n_err++; $display("FAIL handoff_gap: got %b want 0000", grant); end n_cmp++;
        idle_core;
        tick;
        #2;
        if (grant !== 4'b0001) begin n_err++; $display("FAIL handoff_grant: got %b want 0001", grant); end n_cmp++;
    endtask

    // Requester 0 owns the core (mode 3) under stalls; requester 1 waits.
    task automatic test_contend;
        int b;
        longint unsigned s;
        req_mode[3:2] = 2'd2;
        req_valid[1]  = 1'b1;
        #1;
        if (req_ready[1] !== 1'b0) begin n_err++; $display("FAIL contend_ready1_feed: got %b want 0", req_ready[1]); end n_cmp++;
        tick;
        do_feed(0, 2, 'h500, 1'b1, b, s);
        if (b !== 2 || s !== sum_seq('h500, 2)) begin
            n_err++; $display("FAIL contend_feed: got beats=%0d sum=%0h want 2/%0h", b, s, sum_seq('h500, 2));
        end n_cmp++;
        #2;
        if (req_ready[1] !== 1'b0) begin n_err++; $display("FAIL contend_ready1_drain: got %b want 0", req_ready[1]); end n_cmp++;
        tick;
        do_drain(0, 'h600, 1'b1, b, s);
        if (b !== 8) begin n_err++; $display("FAIL mode3_beats: got %0d want 8", b); end n_cmp++;
        if (s !== sum_seq('h600, 8)) begin n_err++; $display("FAIL mode3_sum: got %0h want %0h", s, sum_seq('h600, 8)); end n_cmp++;
        if (core_out_ready !== 1'b0 || grant !== 4'b0000 || req_ready[1] !== 1'b0) begin
            n_err++; $display("FAIL contend_gap: got cor=%b g=%b rr1=%b want 0/0000/0", core_out_ready, grant, req_ready[1]);
        end n_cmp++;
        idle_core;
        tick;
        #2;
        if (grant !== 4'b0010) begin n_err++; $display("FAIL contend_grant1: got %b want 0010", grant); end n_cmp++;
        tick;
        do_feed(1, 4, 'h700, 1'b1, b, s);
        if (b !== 4 || s !== sum_seq('h700, 4)) begin
            n_err++; $display("FAIL stall_feed: got beats=%0d sum=%0h want 4/%0h", b, s, sum_seq('h700, 4));
        end n_cmp++;
        #2;
        tick;
        do_drain(1, 'h800, 1'b1, b, s);
        if (b !== 6) begin n_err++; $display("FAIL mode2_beats: got %0d want 6", b); end n_cmp++;
        if (s !== sum_seq('h800, 6)) begin n_err++; $display("FAIL mode2_sum: got %0h want %0h", s, sum_seq('h800, 6)); end n_cmp++;
        if (core_out_ready !== 1'b0) begin n_err++; $display("FAIL mode2_ready_after: got %b want 0", core_out_ready); end n_cmp++;
        idle_core;
    endtask

    // From ptr=0: 0 before 2, then (ptr=3) 0 again before 2.
    task automatic test_two_req;
        int b;
        longint unsigned s;
        tick;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick;
        req_mode  = '0;
        req_valid = 4'b0101;
        tick;
        #2;
        if (grant !== 4'b0001) begin n_err++; $display("FAIL two_first: got %b want 0001", grant); end n_cmp++;
        for (int round = 0; round < 2; round++) begin
            tick;
            do_feed(0, 1, 'h900 + round, 1'b0, b, s);
            #2;
            tick;
            do_drain(0, 'hA00, 1'b0, b, s);
            idle_core;
            tick;
            #2;
            if (grant !== 4'b0100) begin n_err++; $display("FAIL two_second r%0d: got %b want 0100", round, grant); end n_cmp++;
            tick;
            do_feed(2, 2, 'hB00, 1'b0, b, s);
            #2;
            tick;
            do_drain(2, 'hC00, 1'b0, b, s);
            if (b !== 4) begin n_err++; $display("FAIL two_drain r%0d: got %0d want 4", round, b); end n_cmp++;
            idle_core;
            req_valid = 4'b0101;
            tick;
            #2;
            if (round == 0 && grant !== 4'b0001) begin
                n_err++; $display("FAIL two_wrap: got %b want 0001", grant);
            end
            if (round == 0) n_cmp++;
        end
        req_valid = '0;
    endtask

    // Async reset in DRAIN after 2 of 8 beats; the following grant must come from ptr=0.
    task automatic test_reset_drain;
        int b;
        longint unsigned s;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick;
        req_mode[7:6] = 2'd3;
        req_valid[3]  = 1'b1;
        tick;
        #2;
        if (grant !== 4'b1000 || core_mode !== 2'd3) begin
            n_err++; $display("FAIL rd_grant: got g=%b m=%0d want 1000/3", grant, core_mode);
        end n_cmp++;
        tick;
        do_feed(3, 1, 'hD00, 1'b0, b, s);
        core_out_valid = 1'b1;
        rsp_ready[3]   = 1'b1;
        #2;
        if (rsp_valid !== 4'b1000) begin n_err++; $display("FAIL rd_rsp_onehot: got %b want 1000", rsp_valid); end n_cmp++;
        tick;
        tick;
        #1;
        rst_n = 1'b0;
        #1;
        if (grant !== 4'b0000 || busy !== 1'b0 || rsp_valid !== 4'b0000 || core_out_ready !== 1'b0) begin
            n_err++; $display("FAIL rd_async: got g=%b busy=%b rv=%b cor=%b want 0000/0/0000/0",
                              grant, busy, rsp_valid, core_out_ready);
        end n_cmp++;
        if (core_mode !== 2'd0 || req_ready !== 4'b0000 || core_valid !== 1'b0) begin
            n_err++; $display("FAIL rd_async_feed: got m=%0d rr=%b cv=%b want 0/0000/0", core_mode, req_ready, core_valid);
        end n_cmp++;
        idle_core;
        #1;
        rst_n = 1'b1;
        req_valid = 4'b1001;
        tick;
        #2;
        if (grant !== 4'b0001) begin n_err++; $display("FAIL rd_regrant: got %b want 0001", grant); end n_cmp++;
        req_valid = '0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_ptr_one_beat;
        test_contend;
        test_two_req;
        test_reset_drain;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
